// File: rtl/instruction_memory_loader.sv
// Byte-organised instruction memory with a streaming program loader and a zero-fill sequencer.
// Reads return NB_BYTES consecutive cells (wrapping) packed big-endian.
module instruction_memory_loader #(
  parameter int MEMORY_WIDTH   = 8,
  parameter int MEMORY_DEPTH   = 256,
  parameter int NB_ADDR_DEPTH  = 8,
  parameter int NB_ADDR        = 32,
  parameter int NB_BYTES       = 4,
  parameter int NB_INSTRUCTION = MEMORY_WIDTH * NB_BYTES,
  parameter int OUTPUT_REG     = 0,
  parameter logic [NB_INSTRUCTION-1:0] HALT_PATTERN = '1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_read_enable,
  input  logic [NB_ADDR-1:0]        i_addr,
  output logic [NB_INSTRUCTION-1:0] o_read_data,
  output logic                      o_read_valid,
  output logic                      o_misaligned,
  output logic                      o_out_of_range,
  input  logic                      i_load_start,
  input  logic                      i_load_valid,
  input  logic [MEMORY_WIDTH-1:0]   i_load_data,
  output logic                      o_load_ready,
  output logic [NB_ADDR_DEPTH:0]    o_load_count,
  output logic                      o_load_done,
  output logic                      o_halt_seen,
  input  logic                      i_clear_start,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  localparam logic [NB_ADDR_DEPTH-1:0] BYTE_MASK     = NB_ADDR_DEPTH'(NB_BYTES - 1);
  localparam logic [NB_ADDR_DEPTH-1:0] LAST_CELL     = NB_ADDR_DEPTH'(MEMORY_DEPTH - 1);
  localparam logic [NB_ADDR_DEPTH:0]   FULL_COUNT_M1 = (NB_ADDR_DEPTH + 1)'(MEMORY_DEPTH - 1);

  state_t state_reg, state_next;

  logic [MEMORY_WIDTH-1:0]   mem [MEMORY_DEPTH];
  logic [NB_ADDR_DEPTH-1:0]  ptr_reg;
  logic [NB_ADDR_DEPTH:0]    count_reg;
  logic [NB_INSTRUCTION-1:0] asm_reg;
  logic [NB_INSTRUCTION-1:0] asm_next;
  logic                      halt_seen_reg;
  logic                      done_reg;

  logic load_accept;
  logic clear_write;
  logic word_complete;
  logic halt_hit;
  logic count_full;
  logic start_op;
  logic mem_we;
  logic [MEMORY_WIDTH-1:0] mem_wdata;

  assign load_accept   = (state_reg == LOAD) && i_enable && i_load_valid;
  assign clear_write   = (state_reg == CLEAR) && i_enable;
  assign word_complete = (ptr_reg & BYTE_MASK) == BYTE_MASK;
  assign asm_next      = (asm_reg << MEMORY_WIDTH) | NB_INSTRUCTION'(i_load_data);
  assign halt_hit      = load_accept && word_complete && (asm_next == HALT_PATTERN);
  assign count_full    = load_accept && (count_reg == FULL_COUNT_M1);
  assign start_op      = ((state_reg == IDLE) || (state_reg == DONE)) &&
                         ((state_next == CLEAR) || (state_next == LOAD));
  assign mem_we        = clear_write || load_accept;
  assign mem_wdata     = clear_write ? '0 : i_load_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (i_enable) begin
      case (state_reg)
        IDLE, DONE: begin
          if (i_clear_start)     state_next = CLEAR;
          else if (i_load_start) state_next = LOAD;
        end
        CLEAR: if (ptr_reg == LAST_CELL) state_next = IDLE;
        LOAD:  if (halt_hit || count_full) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_load_ready = (state_reg == LOAD) && i_enable;
    o_busy       = (state_reg == CLEAR) || (state_reg == LOAD);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ptr_reg       <= '0;
      count_reg     <= '0;
      asm_reg       <= '0;
      halt_seen_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else if (i_enable) begin
      done_reg <= (state_next == DONE);
      if (start_op) begin
        ptr_reg       <= '0;
        count_reg     <= '0;
        asm_reg       <= '0;
        halt_seen_reg <= 1'b0;
      end else if (clear_write) begin
        ptr_reg <= ptr_reg + 1'b1;
      end else if (load_accept) begin
        ptr_reg   <= ptr_reg + 1'b1;
        count_reg <= count_reg + 1'b1;
        asm_reg   <= asm_next;
        if (halt_hit) halt_seen_reg <= 1'b1;
      end
    end
  end

  // Memory is deliberately left out of reset so a reset only aborts the sequencers.
  always_ff @(posedge i_clock) begin
    if (mem_we) mem[ptr_reg] <= mem_wdata;
  end

  assign o_load_count = count_reg;
  assign o_load_done  = done_reg;
  assign o_halt_seen  = halt_seen_reg;

  logic [NB_ADDR_DEPTH-1:0]  rd_base;
  logic                      rd_oor;
  logic [MEMORY_WIDTH-1:0]   rd_byte_reg [NB_BYTES];
  logic [NB_INSTRUCTION-1:0] rd_word_s1;
  logic                      rd_valid_s1;
  logic                      rd_mis_s1;
  logic                      rd_oor_s1;

  assign rd_base = i_addr[NB_ADDR_DEPTH-1:0];

  generate
    if (NB_ADDR > NB_ADDR_DEPTH) begin : g_range
      assign rd_oor = |i_addr[NB_ADDR-1:NB_ADDR_DEPTH];
    end else begin : g_no_range
      assign rd_oor = 1'b0;
    end
  endgenerate

  // Same-cycle writes are not forwarded: a colliding read sees the old byte.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < NB_BYTES; k++) rd_byte_reg[k] <= '0;
      rd_valid_s1 <= 1'b0;
      rd_mis_s1   <= 1'b0;
      rd_oor_s1   <= 1'b0;
    end else if (i_enable) begin
      if (i_read_enable) begin
        for (int k = 0; k < NB_BYTES; k++)
          rd_byte_reg[k] <= rd_oor ? '0 : mem[rd_base + NB_ADDR_DEPTH'(k)];
        rd_valid_s1 <= 1'b1;
        rd_mis_s1   <= (rd_base & BYTE_MASK) != '0;
        rd_oor_s1   <= rd_oor;
      end else begin
        for (int k = 0; k < NB_BYTES; k++) rd_byte_reg[k] <= '0;
        rd_valid_s1 <= 1'b0;
        rd_mis_s1   <= 1'b0;
        rd_oor_s1   <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_BYTES; gi++) begin : g_pack
      assign rd_word_s1[NB_INSTRUCTION-1-gi*MEMORY_WIDTH -: MEMORY_WIDTH] = rd_byte_reg[gi];
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          o_read_data    <= '0;
          o_read_valid   <= 1'b0;
          o_misaligned   <= 1'b0;
          o_out_of_range <= 1'b0;
        end else if (i_enable) begin
          o_read_data    <= rd_word_s1;
          o_read_valid   <= rd_valid_s1;
          o_misaligned   <= rd_mis_s1;
          o_out_of_range <= rd_oor_s1;
        end
      end
    end else begin : g_out_direct
      assign o_read_data    = rd_word_s1;
      assign o_read_valid   = rd_valid_s1;
      assign o_misaligned   = rd_mis_s1;
      assign o_out_of_range = rd_oor_s1;
    end
  endgenerate

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: clear, load, halt, wrap, range, enable freeze, reset abort.
module tb_instruction_memory_loader;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic        i_read_enable;
  logic [31:0] i_addr;
  logic [31:0] o_read_data;
  logic        o_read_valid;
  logic        o_misaligned;
  logic        o_out_of_range;
  logic        i_load_start;
  logic        i_load_valid;
  logic [7:0]  i_load_data;
  logic        o_load_ready;
  logic [8:0]  o_load_count;
  logic        o_load_done;
  logic        o_halt_seen;
  logic        i_clear_start;
  logic        o_busy;

  int vectors;
  int miscompares;

  instruction_memory_loader dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_read_enable  (i_read_enable),
    .i_addr         (i_addr),
    .o_read_data    (o_read_data),
    .o_read_valid   (o_read_valid),
    .o_misaligned   (o_misaligned),
    .o_out_of_range (o_out_of_range),
    .i_load_start   (i_load_start),
    .i_load_valid   (i_load_valid),
    .i_load_data    (i_load_data),
    .o_load_ready   (o_load_ready),
    .o_load_count   (o_load_count),
    .o_load_done    (o_load_done),
    .o_halt_seen    (o_halt_seen),
    .i_clear_start  (i_clear_start),
    .o_busy         (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    i_load_valid = 1'b1;
    i_load_data  = d;
    step();
    i_load_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    i_read_enable = 1'b1;
    i_addr        = a;
    step();
    i_read_enable = 1'b0;
    $display("read addr=%h data=%h valid=%b mis=%b oor=%b", a, o_read_data, o_read_valid,
             o_misaligned, o_out_of_range);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    vectors++;
    if ({o_read_data, o_read_valid, o_misaligned, o_out_of_range} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_read: got %h/%b/%b/%b required 0", o_read_data, o_read_valid,
               o_misaligned, o_out_of_range);
    end
    vectors++;
    if ({o_load_ready, o_load_count, o_load_done, o_halt_seen, o_busy} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready=%b count=%0d done=%b halt=%b busy=%b required all 0",
               o_load_ready, o_load_count, o_load_done, o_halt_seen, o_busy);
    end
    $display("test_reset complete");
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    vectors++;
    if (n !== 256) begin
      miscompares++;
      $display("FAIL %s: busy cycles got %0d required 256", name, n);
    end
  endtask

  task automatic test_clear();
    i_clear_start = 1'b1;
    step();
    i_clear_start = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_entry: busy=%b ready=%b required busy=1 ready=0", o_busy, o_load_ready);
    end
    wait_clear("clear_busy_len");
    do_read(32'd0);
    vectors++;
    if (o_read_data !== 32'h0 || o_read_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_read0: got %h valid=%b required 00000000 valid=1", o_read_data, o_read_valid);
    end
    $display("test_clear complete");
  endtask

  task automatic test_load_halt();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    vectors++;
    if (o_load_ready !== 1'b1 || o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL load_entry: ready=%b busy=%b required 1/1", o_load_ready, o_busy);
    end
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    vectors++;
    if (o_load_count !== 9'd8 || o_load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_mid: count=%0d done=%b required 8/0", o_load_count, o_load_done);
    end
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    vectors++;
    if (o_load_done !== 1'b1 || o_halt_seen !== 1'b1 || o_load_count !== 9'd12 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_halt_end: done=%b halt=%b count=%0d busy=%b required 1/1/12/0",
               o_load_done, o_halt_seen, o_load_count, o_busy);
    end
    do_read(32'd4);
    vectors++;
    if (o_read_data !== 32'h05060708 || o_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL load_rd4: got %h mis=%b required 05060708 mis=0", o_read_data, o_misaligned);
    end
    do_read(32'd0);
    vectors++;
    if (o_read_data !== 32'h01020304) begin
      miscompares++;
      $display("FAIL load_rd0: got %h required 01020304", o_read_data);
    end
    step();
    vectors++;
    if (o_read_valid !== 1'b0 || o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL read_idle: got %h valid=%b required 0/0", o_read_data, o_read_valid);
    end
    $display("test_load_halt complete");
  endtask

  task automatic test_toggle_valid();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    vectors++;
    if (o_load_done !== 1'b0 || o_halt_seen !== 1'b0 || o_load_count !== 9'd0) begin
      miscompares++;
      $display("FAIL toggle_restart: done=%b halt=%b count=%0d required 0/0/0",
               o_load_done, o_halt_seen, o_load_count);
    end
    for (int i = 0; i < 12; i++) begin
      i_load_valid = 1'b0;
      i_load_data  = 8'hEE;
      step();
      send_byte((i < 8) ? 8'(8'h11 + i) : 8'hFF);
    end
    vectors++;
    if (o_load_count !== 9'd12 || o_load_done !== 1'b1 || o_halt_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_end: count=%0d done=%b halt=%b required 12/1/1",
               o_load_count, o_load_done, o_halt_seen);
    end
    do_read(32'd0);
    vectors++;
    if (o_read_data !== 32'h11121314) begin
      miscompares++;
      $display("FAIL toggle_rd0: got %h required 11121314", o_read_data);
    end
    do_read(32'd4);
    vectors++;
    if (o_read_data !== 32'h15161718) begin
      miscompares++;
      $display("FAIL toggle_rd4: got %h required 15161718", o_read_data);
    end
    $display("test_toggle_valid complete");
  endtask

  task automatic test_wrap_range();
    logic [7:0] b;
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      if (i == 0)   b = 8'hCC;
      if (i == 1)   b = 8'hDD;
      if (i == 254) b = 8'hAA;
      if (i == 255) b = 8'hBB;
      send_byte(b);
      if (i == 254) begin
        vectors++;
        if (o_load_done !== 1'b0 || o_load_count !== 9'd255) begin
          miscompares++;
          $display("FAIL fill_255: done=%b count=%0d required 0/255", o_load_done, o_load_count);
        end
      end
    end
    vectors++;
    if (o_load_done !== 1'b1 || o_halt_seen !== 1'b0 || o_load_count !== 9'd256) begin
      miscompares++;
      $display("FAIL fill_full: done=%b halt=%b count=%0d required 1/0/256",
               o_load_done, o_halt_seen, o_load_count);
    end
    do_read(32'd254);
    vectors++;
    if (o_read_data !== 32'hAABBCCDD || o_misaligned !== 1'b1 || o_out_of_range !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_rd254: got %h mis=%b oor=%b required AABBCCDD 1 0",
               o_read_data, o_misaligned, o_out_of_range);
    end
    do_read(32'd256);
    vectors++;
    if (o_read_data !== 32'h0 || o_out_of_range !== 1'b1 || o_read_valid !== 1'b1 || o_misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL range_rd256: got %h oor=%b valid=%b mis=%b required 0 1 1 0",
               o_read_data, o_out_of_range, o_read_valid, o_misaligned);
    end
    do_read(32'd8);
    vectors++;
    if (o_read_data !== 32'h08090A0B) begin
      miscompares++;
      $display("FAIL fill_rd8: got %h required 08090A0B", o_read_data);
    end
    $display("test_wrap_range complete");
  endtask

  task automatic test_enable_freeze();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    send_byte(8'h21);
    send_byte(8'h22);
    i_enable     = 1'b0;
    i_load_valid = 1'b1;
    i_load_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (o_load_count !== 9'd2 || o_load_ready !== 1'b0 || o_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL freeze_cyc%0d: count=%0d ready=%b busy=%b required 2/0/1",
                 i, o_load_count, o_load_ready, o_busy);
      end
    end
    i_enable     = 1'b1;
    i_load_valid = 1'b0;
    send_byte(8'h23);
    send_byte(8'h24);
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    vectors++;
    if (o_load_count !== 9'd8 || o_load_done !== 1'b1 || o_halt_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL freeze_resume: count=%0d done=%b halt=%b required 8/1/1",
               o_load_count, o_load_done, o_halt_seen);
    end
    do_read(32'd0);
    vectors++;
    if (o_read_data !== 32'h21222324) begin
      miscompares++;
      $display("FAIL freeze_rd0: got %h required 21222324", o_read_data);
    end
    $display("test_enable_freeze complete");
  endtask

  task automatic test_priority();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    i_clear_start = 1'b1;
    i_load_start  = 1'b1;
    step();
    i_clear_start = 1'b0;
    i_load_start  = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_clear: busy=%b ready=%b required 1/0", o_busy, o_load_ready);
    end
    wait_clear("prio_busy_len");
    do_read(32'd4);
    vectors++;
    if (o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL prio_rd4: got %h required 00000000", o_read_data);
    end
    $display("test_priority complete");
  endtask

  task automatic test_reset_mid_load();
    i_load_start = 1'b1;
    step();
    i_load_start = 1'b0;
    i_read_enable = 1'b1;
    i_addr        = 32'd0;
    send_byte(8'h31);
    vectors++;
    if (o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL collide_rd0: got %h required 00000000", o_read_data);
    end
    send_byte(8'h32);
    vectors++;
    if (o_read_data !== 32'h31000000) begin
      miscompares++;
      $display("FAIL next_cycle_rd0: got %h required 31000000", o_read_data);
    end
    i_read_enable = 1'b0;
    send_byte(8'h33);
    send_byte(8'h34);
    send_byte(8'h35);
    vectors++;
    if (o_load_count !== 9'd5) begin
      miscompares++;
      $display("FAIL midload_count: got %0d required 5", o_load_count);
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    vectors++;
    if ({o_read_data, o_read_valid, o_misaligned, o_out_of_range, o_load_ready,
         o_load_count, o_load_done, o_halt_seen, o_busy} !== 48'h0) begin
      miscompares++;
      $display("FAIL midload_reset: data=%h valid=%b ready=%b count=%0d done=%b halt=%b busy=%b required all 0",
               o_read_data, o_read_valid, o_load_ready, o_load_count, o_load_done, o_halt_seen, o_busy);
    end
    do_read(32'd0);
    vectors++;
    if (o_read_data !== 32'h31323334) begin
      miscompares++;
      $display("FAIL retained_rd0: got %h required 31323334", o_read_data);
    end
    do_read(32'd4);
    vectors++;
    if (o_read_data !== 32'h35000000) begin
      miscompares++;
      $display("FAIL retained_rd4: got %h required 35000000", o_read_data);
    end
    $display("test_reset_mid_load complete");
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    i_reset       = 1'b1;
    i_enable      = 1'b1;
    i_read_enable = 1'b0;
    i_addr        = '0;
    i_load_start  = 1'b0;
    i_load_valid  = 1'b0;
    i_load_data   = '0;
    i_clear_start = 1'b0;
    test_reset();
    test_clear();
    test_load_halt();
    test_toggle_valid();
    test_wrap_range();
    test_enable_freeze();
    test_priority();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Parametrised byte-organised instruction memory for the pipeline's fetch stage, with an integrated program-loader state machine and a hardware clear sequencer. The Debug Unit streams program bytes through a valid/ready handshake instead of driving raw write addresses. The fetch stage reads `NB_BYTES`-wide big-endian instructions with configurable read latency, address wrap-around and alignment/range flags.

## Interface
- `MEMORY_WIDTH`, 8: bits per memory byte cell.
- `MEMORY_DEPTH`, 256: number of byte cells; power of 2.
- `NB_ADDR_DEPTH`, 8: log2(`MEMORY_DEPTH`).
- `NB_ADDR`, 32: fetch address width.
- `NB_BYTES`, 4: bytes per instruction; power of 2, ≤ `MEMORY_DEPTH`.
- `NB_INSTRUCTION`, `MEMORY_WIDTH*NB_BYTES`: instruction width.
- `OUTPUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `HALT_PATTERN`, all ones (`NB_INSTRUCTION` bits): instruction word that terminates a load.

Ports:
- `i_clock` in 1: single clock, all logic on its rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_enable` in 1: global enable from the Debug Unit; low freezes all state, registers and memory writes.
- `i_read_enable` in 1: fetch read request.
- `i_addr` in `NB_ADDR`: byte address of the instruction to read.
- `o_read_data` out `NB_INSTRUCTION`: instruction read from memory.
- `o_read_valid` out 1: `o_read_data` holds the result of a read request.
- `o_misaligned` out 1: the read address was not a multiple of `NB_BYTES`.
- `o_out_of_range` out 1: the read address was ≥ `MEMORY_DEPTH`.
- `i_load_start` in 1: start a program load.
- `i_load_valid` in 1: load byte valid.
- `i_load_data` in `MEMORY_WIDTH`: load byte.
- `o_load_ready` out 1: loader accepts a byte this cycle.
- `o_load_count` out `NB_ADDR_DEPTH+1`: number of bytes written in the current or last load.
- `o_load_done` out 1: a load has completed.
- `o_halt_seen` out 1: the load ended on `HALT_PATTERN`.
- `i_clear_start` in 1: request a zero-fill of the whole memory.
- `o_busy` out 1: the block is in CLEAR or LOAD.

## Operation
- The state machine has four states: IDLE, CLEAR, LOAD, DONE. All transitions require `i_enable`=1.
- **IDLE**
  - `i_clear_start` → CLEAR.
  - Otherwise `i_load_start` → LOAD.
  - If both are asserted in the same cycle, clear wins.
  - Entering CLEAR or LOAD zeroes the write pointer, `o_load_count` and `o_halt_seen`.
- **CLEAR**
  - Writes 0 to the byte at the pointer each enabled cycle and increments the pointer.
  - After writing byte `MEMORY_DEPTH-1` → IDLE.
  - `i_load_start` and `i_clear_start` are ignored while in CLEAR.
- **LOAD**
  - `o_load_ready` = (state==LOAD) & `i_enable`.
  - A byte is accepted on `i_load_valid & o_load_ready`. It is written at the pointer, the pointer increments, `o_load_count` increments, and the byte is shifted into an `NB_INSTRUCTION` assembly register (new byte enters the LSBs).
  - When an accepted byte completes a word (pointer mod `NB_BYTES` == `NB_BYTES-1` before the increment) and the assembled word equals `HALT_PATTERN`: → DONE and set `o_halt_seen`=1.
  - When `o_load_count` reaches `MEMORY_DEPTH`: → DONE. If both conditions occur on the same byte, `o_halt_seen`=1.
  - `i_load_start` is ignored while in LOAD.
- **DONE**
  - `o_load_done`=1.
  - `i_clear_start` → CLEAR.
  - Otherwise `i_load_start` → LOAD, which clears `o_load_done`.
- **Read path** (active in all states)
  - When `i_enable & i_read_enable`: byte k (k = 0..`NB_BYTES-1`) comes from cell (`i_addr[NB_ADDR_DEPTH-1:0]`+k) mod `MEMORY_DEPTH`. Byte 0 goes to the MSBs (big-endian). Set `o_read_valid`=1.
  - `o_misaligned` = low log2(`NB_BYTES`) address bits nonzero.
  - `o_out_of_range` = any of `i_addr[NB_ADDR-1:NB_ADDR_DEPTH]` nonzero. An out-of-range read returns all-zero data, with `o_read_valid`=1 and the flag set.
  - When `i_enable & !i_read_enable`: data, valid and both flags register to 0.
  - When `i_enable`=0: all outputs hold.
  - A misaligned read still returns the wrapped bytes.
- **Read/write collision**: a read of a cell being written in the same cycle (by LOAD or CLEAR) returns the old contents.

## Timing
- Reset:
  - State → IDLE, pointer → 0, assembly register → 0.
  - `o_read_data`, `o_read_valid`, `o_misaligned`, `o_out_of_range`, `o_load_ready`, `o_load_count`, `o_load_done`, `o_halt_seen` and `o_busy` all → 0.
  - Memory contents are not modified by reset.
- Reset mid-LOAD or mid-CLEAR aborts the operation. Bytes already written stay in memory.
- Read latency: a request at edge N is visible after edge N+1 with `OUTPUT_REG`=0, or after edge N+2 with `OUTPUT_REG`=1. The second stage is also gated by `i_enable`.
- Load throughput is one byte per cycle. A write is visible to a read issued on the following cycle.
- CLEAR takes exactly `MEMORY_DEPTH` enabled cycles. `o_busy` drops on the cycle the state returns to IDLE.
- All outputs are registered, except `o_load_ready` and `o_busy`, which are decoded from the registered state and `i_enable`.

## Test plan
- Reset, CLEAR, then read addr 0 → `o_read_data`=0 one cycle later. `o_busy` stays high for exactly 256 cycles.
- Load bytes 01..08 then FF FF FF FF → DONE with `o_halt_seen`=1 and `o_load_count`=12. Reading addr 4 returns 0x05060708.
- Load with `i_load_valid` toggled every other cycle → ready/valid transfers only; the data contents match a back-to-back load.
- Read addr 254 with `NB_BYTES`=4 after loading cells 254,255,0,1 = AA,BB,CC,DD → 0xAABBCCDD with `o_misaligned`=1. Read addr 256 → data 0 with `o_out_of_range`=1.
- Hold `i_enable`=0 mid-LOAD for 5 cycles while `i_load_valid`=1 → no bytes accepted and count frozen. The load resumes correctly when enable returns.
- Assert `i_clear_start` and `i_load_start` together in IDLE → CLEAR is entered. Assert `i_reset` mid-LOAD → all outputs 0 next cycle; the written cells are retained.
